// File: rtl/rst_run_sequencer.sv
// -----------------------------------------------------------------------------
// rst_run_sequencer
//
// Turns one asynchronous active-high board reset into a sequenced, registered
// active-low reset for a downstream design. The reset is held low for RST_HOLD
// cycles, then a run window of RUN_CYCLES cycles is timed and completion is
// flagged with a level (o_done) and a single-cycle pulse (o_done_pulse).
//
// Parameters:
//   RST_HOLD    cycles o_rst_n stays low after synchronised reset release (>= 1)
//   RUN_CYCLES  cycles spent in RUN before completion is flagged (>= 1)
//   CNT_W       width of o_cycle_cnt; 2**CNT_W must exceed RUN_CYCLES
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_restart     synchronous single-cycle request to re-run the sequence
//   o_rst_n       registered active-low reset to the downstream design
//   o_running     high while in RUN
//   o_done        level, high while in DONE
//   o_done_pulse  one-cycle pulse on entry to DONE
//   o_cycle_cnt   cycles elapsed in RUN, saturating at RUN_CYCLES
// -----------------------------------------------------------------------------
module rst_run_sequencer #(
  parameter int unsigned RST_HOLD   = 100,
  parameter int unsigned RUN_CYCLES = 300000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_restart,
  output logic             o_rst_n,
  output logic             o_running,
  output logic             o_done,
  output logic             o_done_pulse,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  // Hold counter only ever reaches RST_HOLD-1.
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_sync;
  logic              w_srst;

  // Release synchroniser: asserts asynchronously with i_rst, releases only
  // after two clean edges so the FSM never sees a metastable deassertion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], 1'b0};
    end
  end

  assign w_srst = r_sync[1];

  // Sequencer FSM with all outputs registered. The synchronised reset and a
  // restart request both return everything to the start of HOLD; the raw
  // i_rst additionally clears asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StHold;
      r_hold_cnt   <= '0;
      o_rst_n      <= 1'b0;
      o_running    <= 1'b0;
      o_done       <= 1'b0;
      o_done_pulse <= 1'b0;
      o_cycle_cnt  <= '0;
    end else if (w_srst || i_restart) begin
      // Restart wins over the RUN->DONE transition, so no pulse escapes.
      r_state      <= StHold;
      r_hold_cnt   <= '0;
      o_rst_n      <= 1'b0;
      o_running    <= 1'b0;
      o_done       <= 1'b0;
      o_done_pulse <= 1'b0;
      o_cycle_cnt  <= '0;
    end else begin
      o_done_pulse <= 1'b0;
      case (r_state)
        StHold: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= StRun;
            r_hold_cnt <= '0;
            o_rst_n    <= 1'b1;
            o_running  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
          end
        end
        StRun: begin
          o_cycle_cnt <= o_cycle_cnt + CNT_ONE;
          if (o_cycle_cnt == RUN_LAST) begin
            r_state      <= StDone;
            o_running    <= 1'b0;
            o_done       <= 1'b1;
            o_done_pulse <= 1'b1;
          end
        end
        StDone: begin
          // Counter holds at RUN_CYCLES; nothing to do until restart/reset.
          o_rst_n <= 1'b1;
          o_done  <= 1'b1;
        end
        default: begin
          r_state     <= StHold;
          r_hold_cnt  <= '0;
          o_rst_n     <= 1'b0;
          o_running   <= 1'b0;
          o_done      <= 1'b0;
          o_cycle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_run_sequencer.sv
module tb_rst_run_sequencer;

  localparam int H = 4;
  localparam int R = 10;

  logic       i_clk;
  logic       i_rst;
  logic       i_restart;
  logic       o_rst_n;
  logic       o_running;
  logic       o_done;
  logic       o_done_pulse;
  logic [7:0] o_cycle_cnt;

  rst_run_sequencer #(
    .RST_HOLD  (H),
    .RUN_CYCLES(R),
    .CNT_W     (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_restart   (i_restart),
    .o_rst_n     (o_rst_n),
    .o_running   (o_running),
    .o_done      (o_done),
    .o_done_pulse(o_done_pulse),
    .o_cycle_cnt (o_cycle_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       rst_n;
    logic       running;
    logic       done;
    logic       pulse;
    logic [7:0] cnt;
  } outs_t;

  typedef struct {
    int    adv;
    bit    rs;
    outs_t exp;
  } vec_t;

  int vectors;
  int miscompares;

  // Reference model: m_n counts edges since reset release (capped at 2, the
  // synchroniser latency); m_e counts edges since the sequence (re)started.
  // Every output is a simple function of m_e.
  int m_n;
  int m_e;

  function automatic outs_t mk(bit rn, bit run, bit dn, bit pl, int c);
    outs_t o;
    o.rst_n   = rn;
    o.running = run;
    o.done    = dn;
    o.pulse   = pl;
    o.cnt     = 8'(c);
    return o;
  endfunction

  function automatic vec_t mv(int adv, bit rs, outs_t e);
    vec_t v;
    v.adv = adv;
    v.rs  = rs;
    v.exp = e;
    return v;
  endfunction

  function automatic outs_t model_out();
    int c;
    c = m_e - H;
    if (c < 0) c = 0;
    if (c > R) c = R;
    return mk(m_e >= H, (m_e >= H) && (m_e < H + R), m_e >= H + R, m_e == H + R, c);
  endfunction

  function automatic outs_t dut_out();
    return mk(o_rst_n, o_running, o_done, o_done_pulse, int'(o_cycle_cnt));
  endfunction

  task automatic model_edge(input bit rs);
    if (m_n < 2) begin
      m_n++;
      m_e = 0;
    end else if (rs) begin
      m_e = 0;
    end else if (m_e < 100000) begin
      m_e++;
    end
  endtask

  task automatic compare(input string name, input outs_t got, input outs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got rst_n=%b run=%b done=%b pulse=%b cnt=%0d, required rst_n=%b run=%b done=%b pulse=%b cnt=%0d",
               name, $time, got.rst_n, got.running, got.done, got.pulse, got.cnt,
               exp.rst_n, exp.running, exp.done, exp.pulse, exp.cnt);
    end
  endtask

  // Called at a negedge; advances one rising edge and compares at next negedge.
  task automatic tick(input bit rs, input string name);
    i_restart = rs;
    @(posedge i_clk);
    model_edge(rs);
    @(negedge i_clk);
    i_restart = 1'b0;
    compare(name, dut_out(), model_out());
  endtask

  // Called at a negedge; 3 ns reset pulse that ends before the next edge.
  task automatic rst_pulse(input string name);
    #1 i_rst = 1'b1;
    #1 compare(name, dut_out(), mk(0, 0, 0, 0, 0));
    m_n = 0;
    m_e = 0;
    #2 i_rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_rst       = 1'b1;
    i_restart   = 1'b0;
    m_n         = 0;
    m_e         = 0;

    // Edge counts below are measured from reset release (edge 1 first).
    tbl.push_back(mv(5,  1'b0, mk(0, 0, 0, 0, 0)));   // edge 5: still held
    tbl.push_back(mv(1,  1'b0, mk(1, 1, 0, 0, 0)));   // edge 6: o_rst_n rises
    tbl.push_back(mv(5,  1'b0, mk(1, 1, 0, 0, 5)));   // edge 11
    tbl.push_back(mv(4,  1'b0, mk(1, 1, 0, 0, 9)));   // edge 15: last RUN
    tbl.push_back(mv(1,  1'b0, mk(1, 0, 1, 1, 10)));  // edge 16: DONE + pulse
    tbl.push_back(mv(1,  1'b0, mk(1, 0, 1, 0, 10)));  // pulse is one cycle
    tbl.push_back(mv(20, 1'b0, mk(1, 0, 1, 0, 10)));  // saturated, no wrap
    tbl.push_back(mv(1,  1'b1, mk(0, 0, 0, 0, 0)));   // restart from DONE
    tbl.push_back(mv(3,  1'b0, mk(0, 0, 0, 0, 0)));
    tbl.push_back(mv(1,  1'b0, mk(1, 1, 0, 0, 0)));   // restart + 4
    tbl.push_back(mv(9,  1'b0, mk(1, 1, 0, 0, 9)));   // restart + 13
    tbl.push_back(mv(1,  1'b1, mk(0, 0, 0, 0, 0)));   // restart beats DONE
    tbl.push_back(mv(3,  1'b1, mk(0, 0, 0, 0, 0)));   // restart held
    tbl.push_back(mv(4,  1'b0, mk(1, 1, 0, 0, 0)));
    tbl.push_back(mv(10, 1'b0, mk(1, 0, 1, 1, 10)));  // restart + 14: DONE

    repeat (2) @(negedge i_clk);
    compare("reset_state", dut_out(), mk(0, 0, 0, 0, 0));
    rst_pulse("reset_enter");

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].adv; k++) tick(tbl[i].rs, "table_model");
      compare($sformatf("table_%0d", i), dut_out(), tbl[i].exp);
    end

    // Abort mid-RUN with a sub-cycle reset pulse, then the full sequence again.
    rst_pulse("abort_enter");
    repeat (11) tick(1'b0, "abort_pre");
    compare("abort_cnt5", dut_out(), mk(1, 1, 0, 0, 5));
    rst_pulse("abort_clear");
    repeat (2) tick(1'b0, "abort_sync");
    compare("abort_sync_held", dut_out(), mk(0, 0, 0, 0, 0));
    repeat (4) tick(1'b0, "abort_hold");
    compare("abort_rst_n_e6", dut_out(), mk(1, 1, 0, 0, 0));
    repeat (10) tick(1'b0, "abort_run");
    compare("abort_done_e16", dut_out(), mk(1, 0, 1, 1, 10));

    // Random restarts and reset pulses against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) rst_pulse("rand_rst");
      tick($urandom_range(0, 99) < 4, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
